// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU opcodes, FSM state encodings and flag bit positions for the ALU share arbiter.
// Purely declarative: no logic, no latency, no backpressure.
package alu_share_arbiter_pkg;

  localparam logic [3:0] ALU_FWD  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_DIFF = 4'b0100;
  localparam logic [3:0] ALU_COMP = 4'b0101;
  localparam logic [3:0] ALU_SLLV = 4'b1000;
  localparam logic [3:0] ALU_SRLV = 4'b1010;
  localparam logic [3:0] ALU_SRAV = 4'b1011;
  localparam logic [3:0] ALU_SLL  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1110;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_SIGN  = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_EQUAL = 3;

  function automatic logic [3:0] pack_flags(input logic feq, input logic fc,
                                            input logic fs, input logic fz);
    logic [3:0] f;
    f             = '0;
    f[FLAG_EQUAL] = feq;
    f[FLAG_CARRY] = fc;
    f[FLAG_SIGN]  = fs;
    f[FLAG_ZERO]  = fz;
    return f;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Two requester ports plus the shared response bus of the ALU share arbiter.
// master = requester side (drives requests and response-ready), slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             r0_valid;
  logic             r0_ready;
  logic [WIDTH-1:0] r0_A;
  logic [WIDTH-1:0] r0_B;
  logic [3:0]       r0_code;
  logic [4:0]       r0_shamt;
  logic             r0_rvalid;
  logic             r0_rready;

  logic             r1_valid;
  logic             r1_ready;
  logic [WIDTH-1:0] r1_A;
  logic [WIDTH-1:0] r1_B;
  logic [3:0]       r1_code;
  logic [4:0]       r1_shamt;
  logic             r1_rvalid;
  logic             r1_rready;

  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_id;

  modport master (
    output r0_valid, r0_A, r0_B, r0_code, r0_shamt, r0_rready,
    output r1_valid, r1_A, r1_B, r1_code, r1_shamt, r1_rready,
    input  r0_ready, r0_rvalid, r1_ready, r1_rvalid,
    input  rsp_result, rsp_flags, rsp_id
  );

  modport slave (
    input  r0_valid, r0_A, r0_B, r0_code, r0_shamt, r0_rready,
    input  r1_valid, r1_A, r1_B, r1_code, r1_shamt, r1_rready,
    output r0_ready, r0_rvalid, r1_ready, r1_rvalid,
    output rsp_result, rsp_flags, rsp_id
  );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU with {equal,carry,sign,zero} flags; zero latency, no handshake.
// Carry is the adder carry-out for ADD/DIFF (DIFF: 1 means no borrow), 0 otherwise.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_code,
  input  logic [4:0]       i_shamt,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  logic             w_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;
  logic             w_lt;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;

  always_comb begin
    w_sub    = (i_code == ALU_DIFF) || (i_code == ALU_COMP);
    w_b_op   = w_sub ? ~i_b : i_b;
    w_sum    = {1'b0, i_a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub};
    // signed less-than: differing signs decide directly, otherwise the difference's sign
    w_lt     = (i_a[WIDTH-1] != i_b[WIDTH-1]) ? i_a[WIDTH-1] : w_sum[WIDTH-1];
    w_result = '0;
    w_carry  = 1'b0;
    case (i_code)
      ALU_FWD:  w_result = i_a;
      ALU_ADD:  begin w_result = w_sum[WIDTH-1:0]; w_carry = w_sum[WIDTH]; end
      ALU_AND:  w_result = i_a & i_b;
      ALU_XOR:  w_result = i_a ^ i_b;
      ALU_DIFF: begin w_result = w_sum[WIDTH-1:0]; w_carry = w_sum[WIDTH]; end
      ALU_COMP: w_result = {{(WIDTH-1){1'b0}}, w_lt};
      ALU_SLLV: w_result = i_a << i_b[4:0];
      ALU_SRLV: w_result = i_a >> i_b[4:0];
      ALU_SRAV: w_result = $signed(i_a) >>> i_b[4:0];
      ALU_SLL:  w_result = i_a << i_shamt;
      ALU_SRL:  w_result = i_a >> i_shamt;
      ALU_SRA:  w_result = $signed(i_a) >>> i_shamt;
      default:  w_result = '0;
    endcase
  end

  assign o_result = w_result;
  assign o_flags  = pack_flags(i_a == i_b, w_carry, w_result[WIDTH-1], w_result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters (RR or fixed priority); accept -> result 2 edges later.
// rX_ready only in IDLE (also in RESP on handshake with ALU_ARB_B2B_EN); result held until rready.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus
);

  logic [1:0]       r_state;
  logic             r_last_grant;
  logic             r_gnt_id;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic [3:0]       r_rsp_flags;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [3:0]       r_op_code;
  logic [4:0]       r_op_shamt;

  logic             w_any;
  logic             w_win;
  logic             w_rsp_hs;
  logic             w_can_accept;
  logic             w_accept;
  logic [WIDTH-1:0] w_alu_result;
  logic [3:0]       w_alu_flags;

  always_comb begin
    w_any = bus.r0_valid || bus.r1_valid;
    if (FIXED_PRIO)
      w_win = !bus.r0_valid;
    else if (bus.r0_valid && bus.r1_valid)
      w_win = !r_last_grant;
    else
      w_win = !bus.r0_valid;
    // rready of the non-owning port never completes the response
    w_rsp_hs = (r_state == ST_RESP) && (r_rsp_id ? bus.r1_rready : bus.r0_rready);
`ifdef ALU_ARB_B2B_EN
    w_can_accept = (r_state == ST_IDLE) || w_rsp_hs;
`else
    w_can_accept = (r_state == ST_IDLE);
`endif
    w_accept = !rst && w_any && w_can_accept;
  end

  assign bus.r0_ready   = w_accept && !w_win;
  assign bus.r1_ready   = w_accept && w_win;
  assign bus.r0_rvalid  = (r_state == ST_RESP) && !r_rsp_id;
  assign bus.r1_rvalid  = (r_state == ST_RESP) && r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_flags  = r_rsp_flags;
  assign bus.rsp_id     = r_rsp_id;

  alu_share_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a      (r_op_a),
    .i_b      (r_op_b),
    .i_code   (r_op_code),
    .i_shamt  (r_op_shamt),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_gnt_id     <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) r_state <= ST_EXEC;
        ST_EXEC: begin
          r_rsp_result <= w_alu_result;
          r_rsp_flags  <= w_alu_flags;
          r_rsp_id     <= r_gnt_id;
          r_state      <= ST_RESP;
        end
        ST_RESP: if (w_rsp_hs) r_state <= w_accept ? ST_EXEC : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_accept) begin
        r_gnt_id     <= w_win;
        r_last_grant <= w_win;
      end
    end
  end

  // operand registers carry no reset: an op in flight at reset is discarded anyway
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op_a     <= w_win ? bus.r1_A     : bus.r0_A;
      r_op_b     <= w_win ? bus.r1_B     : bus.r0_B;
      r_op_code  <= w_win ? bus.r1_code  : bus.r0_code;
      r_op_shamt <= w_win ? bus.r1_shamt : bus.r0_shamt;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: stimulus pushes hand-computed responses into per-DUT queues,
// monitors pop and compare on every completed response handshake.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(32)) bus ();
  alu_share_arbiter_if #(.WIDTH(32)) bus_fp ();

  alu_share_arbiter #(.WIDTH(32), .FIXED_PRIO(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_share_arbiter #(.WIDTH(32), .FIXED_PRIO(1'b1)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_fp)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic [3:0]  flags;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int n_checks = 0;
  int n_pass   = 0;

`ifdef ALU_ARB_B2B_EN
  localparam int EXP_GAP = 2;
`else
  localparam int EXP_GAP = 3;
`endif

  function automatic exp_t mk(input logic id, input logic [31:0] res, input logic [3:0] fl);
    exp_t e;
    e.id = id; e.result = res; e.flags = fl;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // response monitor for the round-robin DUT
  always @(negedge clk) begin
    if (!rst && ((bus.r0_rvalid && bus.r0_rready) || (bus.r1_rvalid && bus.r1_rready))) begin
      if (q0.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got id=%0d result=%0d, expected no response",
                 bus.rsp_id, bus.rsp_result);
      end else begin
        e0 = q0.pop_front();
        chk("rsp_id", bus.rsp_id, e0.id);
        chk("rsp_result", bus.rsp_result, e0.result);
        chk("rsp_flags", bus.rsp_flags, e0.flags);
        chk("rvalid_port", bus.r1_rvalid, e0.id);
        chk("rvalid_other", e0.id ? bus.r0_rvalid : bus.r1_rvalid, 0);
      end
    end
  end

  // response monitor for the fixed-priority DUT
  always @(negedge clk) begin
    if (!rst && ((bus_fp.r0_rvalid && bus_fp.r0_rready) || (bus_fp.r1_rvalid && bus_fp.r1_rready))) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL fp_unexpected_rsp: got id=%0d result=%0d, expected no response",
                 bus_fp.rsp_id, bus_fp.rsp_result);
      end else begin
        e1 = q1.pop_front();
        chk("fp_rsp_id", bus_fp.rsp_id, e1.id);
        chk("fp_rsp_result", bus_fp.rsp_result, e1.result);
        chk("fp_rsp_flags", bus_fp.rsp_flags, e1.flags);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  task automatic issue(input bit port, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] code, input logic [4:0] shamt, input string name);
    bit got;
    got = 1'b0;
    if (!port) begin
      bus.r0_A = a; bus.r0_B = b; bus.r0_code = code; bus.r0_shamt = shamt; bus.r0_valid = 1'b1;
    end else begin
      bus.r1_A = a; bus.r1_B = b; bus.r1_code = code; bus.r1_shamt = shamt; bus.r1_valid = 1'b1;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = port ? bus.r1_ready : bus.r0_ready;
    end
    chk({name, "_accept"}, got, 1);
    @(posedge clk); #1;
    if (!port) bus.r0_valid = 1'b0;
    else       bus.r1_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (n < 40 && (q0.size() != 0 || q1.size() != 0 || bus.r0_rvalid || bus.r1_rvalid ||
                      bus_fp.r0_rvalid || bus_fp.r1_rvalid)) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, q0.size() + q1.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int g, g0, g1e, cnt, last, hi;
    bit got;

    rst = 1'b1;
    bus.r0_valid = 1'b1; bus.r0_A = '0; bus.r0_B = '0; bus.r0_code = '0; bus.r0_shamt = '0;
    bus.r1_valid = 1'b0; bus.r1_A = '0; bus.r1_B = '0; bus.r1_code = '0; bus.r1_shamt = '0;
    bus.r0_rready = 1'b1; bus.r1_rready = 1'b1;
    bus_fp.r0_valid = 1'b0; bus_fp.r0_A = '0; bus_fp.r0_B = '0; bus_fp.r0_code = '0; bus_fp.r0_shamt = '0;
    bus_fp.r1_valid = 1'b0; bus_fp.r1_A = '0; bus_fp.r1_B = '0; bus_fp.r1_code = '0; bus_fp.r1_shamt = '0;
    bus_fp.r0_rready = 1'b1; bus_fp.r1_rready = 1'b1;

    // reset state, with a request pending that must not be accepted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_r0_ready", bus.r0_ready, 0);
    chk("rst_r1_ready", bus.r1_ready, 0);
    chk("rst_r0_rvalid", bus.r0_rvalid, 0);
    chk("rst_r1_rvalid", bus.r1_rvalid, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_flags", bus.rsp_flags, 0);
    chk("rst_id", bus.rsp_id, 0);
    @(posedge clk); #1;
    bus.r0_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: port 0 ADD 12+11 = 23, response two edges after acceptance
    q0.push_back(mk(1'b0, 32'd23, 4'b0000));
    issue(1'b0, 32'd12, 32'd11, ALU_ADD, 5'd0, "t1");
    @(negedge clk);
    chk("t1_rvalid_in_exec", bus.r0_rvalid, 0);
    @(negedge clk);
    chk("t1_rvalid_in_resp", bus.r0_rvalid, 1);
    drain("t1");

    // 4: port 1 SLL 4<<2 = 16 held while r1_rready is low; r0_rready toggles ignored
    bus.r1_rready = 1'b0;
    q0.push_back(mk(1'b1, 32'd16, 4'b0000));
    issue(1'b1, 32'd4, 32'd0, ALU_SLL, 5'd2, "t4");
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.r1_rvalid;
    end
    chk("t4_rvalid", got, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_rvalid", bus.r1_rvalid, 1);
      chk("t4_hold_result", bus.rsp_result, 32'd16);
      chk("t4_r0_rvalid", bus.r0_rvalid, 0);
      @(posedge clk); #1;
      bus.r0_rready = ~bus.r0_rready;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.r0_rready = 1'b1;
    bus.r1_rready = 1'b1;
    drain("t4");

    // 5: reset during EXEC of DIFF 172-124 discards it; the reissue returns 48
    issue(1'b0, 32'd172, 32'd124, ALU_DIFF, 5'd0, "t5a");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_r0_rvalid", bus.r0_rvalid, 0);
    chk("t5_r1_rvalid", bus.r1_rvalid, 0);
    chk("t5_result_cleared", bus.rsp_result, 0);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.r0_rvalid || bus.r1_rvalid) hi++;
    end
    chk("t5_no_response", hi, 0);
    @(posedge clk); #1;
    q0.push_back(mk(1'b0, 32'd48, 4'b0100));
    issue(1'b0, 32'd172, 32'd124, ALU_DIFF, 5'd0, "t5b");
    drain("t5");

    // 2: both valid continuously after reset -> grants 0,1,0,1
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.push_back(mk(1'b0, 32'd7, 4'b0000));
    q0.push_back(mk(1'b1, 32'd8, 4'b0000));
    q0.push_back(mk(1'b0, 32'd7, 4'b0000));
    q0.push_back(mk(1'b1, 32'd8, 4'b0000));
    bus.r0_A = 32'd15; bus.r0_B = 32'd8; bus.r0_code = ALU_XOR; bus.r0_valid = 1'b1;
    bus.r1_A = 32'd15; bus.r1_B = 32'd8; bus.r1_code = ALU_AND; bus.r1_valid = 1'b1;
    g = 0;
    for (int i = 0; i < 60 && g < 4; i++) begin
      @(negedge clk);
      if (bus.r0_ready || bus.r1_ready) begin
        chk("t2_grant_seq", bus.r1_ready, g % 2);
        chk("t2_one_ready", bus.r0_ready & bus.r1_ready, 0);
        g++;
        if (g == 4) begin
          @(posedge clk); #1;
          bus.r0_valid = 1'b0;
          bus.r1_valid = 1'b0;
        end
      end
    end
    chk("t2_grants", g, 4);
    drain("t2");

    // 3: fixed priority, both valid -> port 0 four times, then port 1 XOR 5^5 = 0
    for (int i = 0; i < 4; i++) q1.push_back(mk(1'b0, 32'd2, 4'b1000));
    q1.push_back(mk(1'b1, 32'd0, 4'b1001));
    bus_fp.r0_A = 32'd1; bus_fp.r0_B = 32'd1; bus_fp.r0_code = ALU_ADD; bus_fp.r0_valid = 1'b1;
    bus_fp.r1_A = 32'd5; bus_fp.r1_B = 32'd5; bus_fp.r1_code = ALU_XOR; bus_fp.r1_valid = 1'b1;
    g0 = 0; g1e = 0;
    for (int i = 0; i < 80 && g0 < 4; i++) begin
      @(negedge clk);
      if (bus_fp.r1_ready) g1e++;
      if (bus_fp.r0_ready) begin
        g0++;
        if (g0 == 4) begin
          @(posedge clk); #1;
          bus_fp.r0_valid = 1'b0;
        end
      end
    end
    chk("t3_p0_grants", g0, 4);
    chk("t3_p1_starved", g1e, 0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus_fp.r1_ready;
    end
    chk("t3_p1_accept", got, 1);
    @(posedge clk); #1;
    bus_fp.r1_valid = 1'b0;
    drain("t3");

    // 6: continuous port 0 requests -> ready spacing 3 cycles (2 with back-to-back)
    for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, 32'd23, 4'b0000));
    bus.r0_A = 32'd12; bus.r0_B = 32'd11; bus.r0_code = ALU_ADD; bus.r0_valid = 1'b1;
    cnt = 0; last = 0;
    for (int i = 0; i < 80 && cnt < 4; i++) begin
      @(negedge clk);
      if (bus.r0_ready) begin
        if (cnt > 0) chk("t6_ready_interval", i - last, EXP_GAP);
        last = i;
        cnt++;
        if (cnt == 4) begin
          @(posedge clk); #1;
          bus.r0_valid = 1'b0;
        end
      end
    end
    chk("t6_accepts", cnt, 4);
    drain("t6");

    chk("final_queues_empty", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
